// File: rtl/adc_frame_sequencer.sv
// XADC acquisition sequencer: programs the wrapper, unpacks single/paired results
// into a FWFT sample FIFO with frame tagging. Optional ADC_SIGNED_OUT_EN: two's complement output.
module adc_frame_sequencer #(
  parameter int FIFO_DEPTH = 16,
  parameter int FRAME_W    = 10
) (
  input  logic               hclk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               cfg_double,
  input  logic [15:0]        cfg_div,
  input  logic [FRAME_W-1:0] cfg_frame_len,
  output logic               adc_enable,
  output logic               adc_double,
  output logic [15:0]        adc_div,
  input  logic [23:0]        adc_dout,
  input  logic               adc_drdy,
  output logic [11:0]        smp_data,
  output logic               smp_valid,
  input  logic               smp_ready,
  output logic               smp_last,
  output logic               frame_done,
  output logic               busy,
  output logic               overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]        FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]        CNT_INC  = (AW+1)'(1);
  localparam logic [AW-1:0]      PTR_INC  = AW'(1);
  localparam logic [FRAME_W-1:0] FRM_INC  = FRAME_W'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state_q;
  logic               enable_q;
  logic               double_q;
  logic [15:0]        div_q;
  logic [FRAME_W-1:0] frame_len_q;
  logic [FRAME_W-1:0] cnt_q;
  logic               pend_valid_q;
  logic [11:0]        pend_data_q;
  logic               frame_done_q;
  logic               overflow_q;
  logic [12:0]        mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wptr_q;
  logic [AW-1:0]      rptr_q;
  logic [AW:0]        count_q;

  logic        push_req;
  logic [11:0] push_data;
  logic        pend_load;
  logic        drdy_drop;
  logic        pop;
  logic        push_ok;
  logic        push_drop;
  logic        frame_last;
  logic [12:0] head;

  // A queued upper half always owns the push slot; a result arriving meanwhile is lost.
  always_comb begin
    push_req  = 1'b0;
    push_data = pend_data_q;
    pend_load = 1'b0;
    drdy_drop = 1'b0;
    if (pend_valid_q) begin
      push_req  = 1'b1;
      drdy_drop = adc_drdy && (state_q == RUN);
    end else if (adc_drdy && (state_q == RUN)) begin
      push_req  = 1'b1;
      push_data = adc_dout[11:0];
      pend_load = double_q;
    end
  end

  assign smp_valid  = (count_q != '0);
  assign pop        = smp_valid && smp_ready;
  assign push_ok    = push_req && ((count_q != FULL_CNT) || pop);
  assign push_drop  = push_req && !push_ok;
  // frame_len of 0 wraps to all-ones, giving a 2^FRAME_W sample frame for free.
  assign frame_last = (cnt_q == (frame_len_q - FRM_INC));
  assign head       = mem_q[rptr_q];

  always_ff @(posedge hclk) begin
    if (push_ok) mem_q[wptr_q] <= {frame_last, push_data};
  end

  always_ff @(posedge hclk) begin
    if (rst) begin
      state_q      <= IDLE;
      enable_q     <= 1'b0;
      double_q     <= 1'b0;
      div_q        <= '0;
      frame_len_q  <= '0;
      cnt_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
    end else begin
      frame_done_q <= push_ok && frame_last;
      if (push_drop || drdy_drop) overflow_q <= 1'b1;
      if (push_ok) begin
        wptr_q <= wptr_q + PTR_INC;
        cnt_q  <= frame_last ? '0 : cnt_q + FRM_INC;
      end
      if (pop) rptr_q <= rptr_q + PTR_INC;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CNT_INC;
        2'b01:   count_q <= count_q - CNT_INC;
        default: ;
      endcase
      if (pend_load) begin
        pend_valid_q <= 1'b1;
        pend_data_q  <= adc_dout[23:12];
      end else if (pend_valid_q) begin
        pend_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            state_q     <= RUN;
            enable_q    <= 1'b1;
            double_q    <= cfg_double;
            div_q       <= cfg_div;
            frame_len_q <= cfg_frame_len;
            cnt_q       <= '0;
            overflow_q  <= 1'b0;
          end
        end
        RUN: begin
          if (stop) begin
            state_q  <= DRAIN;
            enable_q <= 1'b0;
          end
        end
        DRAIN: begin
          if ((count_q == '0) && !pend_valid_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign adc_enable = enable_q;
  assign adc_double = double_q;
  assign adc_div    = div_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q != IDLE);
  assign smp_last   = smp_valid && head[12];

`ifdef ADC_SIGNED_OUT_EN
  assign smp_data = smp_valid ? (head[11:0] ^ 12'h800) : 12'h000;
`else
  assign smp_data = smp_valid ? head[11:0] : 12'h000;
`endif

endmodule

// File: tb/tb_adc_frame_sequencer.sv
// Scoreboard bench for adc_frame_sequencer: expected samples are queued as the
// wrapper model fires drdy and compared as the consumer accepts them.
module tb_adc_frame_sequencer;

  localparam int FRAME_W = 10;

  logic               hclk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic               cfg_double = 1'b0;
  logic [15:0]        cfg_div = '0;
  logic [FRAME_W-1:0] cfg_frame_len = '0;
  logic               adc_enable;
  logic               adc_double;
  logic [15:0]        adc_div;
  logic [23:0]        adc_dout = '0;
  logic               adc_drdy = 1'b0;
  logic [11:0]        smp_data;
  logic               smp_valid;
  logic               smp_ready = 1'b0;
  logic               smp_last;
  logic               frame_done;
  logic               busy;
  logic               overflow;

  int vectors = 0;
  int miscompares = 0;
  int exp_cnt = 0;
  int exp_len = 4;
  int fd_cnt = 0;
  int pops = 0;
  int fd_base;
  int pop_base;
  logic [12:0] sb [$];

  adc_frame_sequencer #(.FIFO_DEPTH(16), .FRAME_W(FRAME_W)) dut (
    .hclk(hclk), .rst(rst), .start(start), .stop(stop),
    .cfg_double(cfg_double), .cfg_div(cfg_div), .cfg_frame_len(cfg_frame_len),
    .adc_enable(adc_enable), .adc_double(adc_double), .adc_div(adc_div),
    .adc_dout(adc_dout), .adc_drdy(adc_drdy),
    .smp_data(smp_data), .smp_valid(smp_valid), .smp_ready(smp_ready),
    .smp_last(smp_last), .frame_done(frame_done), .busy(busy), .overflow(overflow)
  );

  always #5 hclk = ~hclk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] conv(input logic [11:0] d);
`ifdef ADC_SIGNED_OUT_EN
    return d ^ 12'h800;
`else
    return d;
`endif
  endfunction

  // Reference frame counter: tags each accepted sample with its expected last flag.
  task automatic pushExp(input logic [11:0] d);
    logic last;
    last = (exp_cnt == exp_len - 1);
    exp_cnt = last ? 0 : exp_cnt + 1;
    sb.push_back({last, conv(d)});
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic applyStimulus(input logic [23:0] d, input bit dbl);
    adc_dout = d;
    adc_drdy = 1'b1;
    pushExp(d[11:0]);
    if (dbl) pushExp(d[23:12]);
    tick();
    adc_drdy = 1'b0;
  endtask

  task automatic startRun(input bit dbl, input logic [15:0] div, input int len);
    cfg_double = dbl;
    cfg_div = div;
    cfg_frame_len = FRAME_W'(len);
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_cnt = 0;
    exp_len = (len == 0) ? (1 << FRAME_W) : len;
  endtask

  task automatic stopRun();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 200 && busy !== 1'b0; i++) tick();
    checkOutput("drain_to_idle", busy, 1'b0);
  endtask

  task automatic waitSbEmpty();
    for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
    checkOutput("scoreboard_empty", sb.size(), 0);
  endtask

  always @(negedge hclk) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (!rst && smp_valid === 1'b1 && smp_ready === 1'b1) begin
      pops++;
      if (sb.size() == 0) begin
        checkOutput("unexpected_sample", {19'd0, smp_last, smp_data}, 32'hFFFF_FFFF);
      end else begin
        logic [12:0] e;
        e = sb.pop_front();
        checkOutput("smp_data", smp_data, e[11:0]);
        checkOutput("smp_last", smp_last, e[12]);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    checkOutput("rst_enable", adc_enable, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_valid", smp_valid, 1'b0);
    checkOutput("rst_data", smp_data, 12'h000);
    checkOutput("rst_overflow", overflow, 1'b0);
    checkOutput("rst_div", adc_div, 16'h0);
    checkOutput("rst_last", smp_last, 1'b0);
    rst = 1'b0;
    tick();

    // Single mode, one full frame of four.
    smp_ready = 1'b1;
    startRun(1'b0, 16'd99, 4);
    checkOutput("run_enable", adc_enable, 1'b1);
    checkOutput("run_busy", busy, 1'b1);
    checkOutput("run_div", adc_div, 16'd99);
    checkOutput("run_double", adc_double, 1'b0);
    fd_base = fd_cnt;
    applyStimulus(24'h000123, 1'b0); repeat (3) tick();
    applyStimulus(24'h000456, 1'b0); repeat (3) tick();
    applyStimulus(24'h000789, 1'b0); repeat (3) tick();
    applyStimulus(24'h000ABC, 1'b0);
    waitSbEmpty();
    repeat (2) tick();
    checkOutput("single_frame_done", fd_cnt - fd_base, 1);
    checkOutput("single_overflow", overflow, 1'b0);

    // Config changes and a second start are ignored while running.
    cfg_div = 16'd7;
    cfg_double = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checkOutput("iso_div", adc_div, 16'd99);
    checkOutput("iso_double", adc_double, 1'b0);
    stopRun();
    checkOutput("stop_enable", adc_enable, 1'b0);
    waitIdle();
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    tick();
    checkOutput("start_stop_busy", busy, 1'b0);
    checkOutput("start_stop_enable", adc_enable, 1'b0);

    // Double mode: both halves appear on consecutive cycles.
    startRun(1'b1, 16'd20, 4);
    checkOutput("dbl_double", adc_double, 1'b1);
    fd_base = fd_cnt;
    applyStimulus(24'hB22A11, 1'b1);
    @(negedge hclk);
    checkOutput("dbl_first", smp_data, conv(12'hA11));
    @(negedge hclk);
    checkOutput("dbl_second", smp_data, conv(12'hB22));
    tick();
    repeat (2) tick();
    applyStimulus(24'h333444, 1'b1);
    waitSbEmpty();
    repeat (2) tick();
    checkOutput("dbl_frame_done", fd_cnt - fd_base, 1);
    checkOutput("dbl_overflow_clear", overflow, 1'b0);
    adc_dout = 24'h555666;
    adc_drdy = 1'b1;
    pushExp(12'h666);
    pushExp(12'h555);
    tick();
    adc_dout = 24'h777888;
    tick();
    adc_drdy = 1'b0;
    tick();
    checkOutput("pending_drop_overflow", overflow, 1'b1);
    waitSbEmpty();
    stopRun();
    waitIdle();

    // Stop with five entries queued and an upper half pending.
    smp_ready = 1'b0;
    startRun(1'b1, 16'd5, 16);
    checkOutput("start_clears_overflow", overflow, 1'b0);
    applyStimulus(24'h002001, 1'b1); repeat (2) tick();
    applyStimulus(24'h004003, 1'b1); repeat (2) tick();
    adc_dout = 24'h006005;
    adc_drdy = 1'b1;
    stop = 1'b1;
    pushExp(12'h005);
    pushExp(12'h006);
    tick();
    adc_drdy = 1'b0;
    stop = 1'b0;
    checkOutput("drain_enable", adc_enable, 1'b0);
    checkOutput("drain_busy", busy, 1'b1);
    repeat (3) tick();
    checkOutput("drain_busy_held", busy, 1'b1);
    pop_base = pops;
    smp_ready = 1'b1;
    waitIdle();
    checkOutput("drain_pops", pops - pop_base, 6);
    checkOutput("drain_sb", sb.size(), 0);

    // Overflow: 17 samples into a 16-deep FIFO with the consumer stalled.
    smp_ready = 1'b0;
    startRun(1'b0, 16'd99, 5);
    fd_base = fd_cnt;
    for (int i = 0; i < 17; i++) begin
      adc_dout = 24'(12'h100 + i);
      adc_drdy = 1'b1;
      if (i < 16) pushExp(12'(12'h100 + i));
      tick();
    end
    adc_drdy = 1'b0;
    tick();
    checkOutput("ovf_flag", overflow, 1'b1);
    checkOutput("ovf_valid", smp_valid, 1'b1);
    smp_ready = 1'b1;
    waitSbEmpty();
    applyStimulus(24'h000201, 1'b0); tick();
    applyStimulus(24'h000202, 1'b0); tick();
    applyStimulus(24'h000203, 1'b0); tick();
    applyStimulus(24'h000204, 1'b0);
    waitSbEmpty();
    repeat (2) tick();
    checkOutput("ovf_frame_done", fd_cnt - fd_base, 4);
    stopRun();
    waitIdle();
    checkOutput("ovf_sticky_idle", overflow, 1'b1);
    startRun(1'b0, 16'd99, 5);
    checkOutput("ovf_cleared_by_start", overflow, 1'b0);
    stopRun();
    waitIdle();

    // Reset in the middle of a run discards everything.
    smp_ready = 1'b0;
    startRun(1'b1, 16'd99, 8);
    adc_dout = 24'h0AA0BB;
    adc_drdy = 1'b1;
    tick();
    adc_dout = 24'h0CC0DD;
    tick();
    adc_drdy = 1'b0;
    tick();
    checkOutput("pre_rst_overflow", overflow, 1'b1);
    checkOutput("pre_rst_valid", smp_valid, 1'b1);
    rst = 1'b1;
    tick();
    checkOutput("mid_rst_valid", smp_valid, 1'b0);
    checkOutput("mid_rst_enable", adc_enable, 1'b0);
    checkOutput("mid_rst_busy", busy, 1'b0);
    checkOutput("mid_rst_overflow", overflow, 1'b0);
    checkOutput("mid_rst_double", adc_double, 1'b0);
    rst = 1'b0;
    sb.delete();
    smp_ready = 1'b1;
    repeat (2) tick();
    checkOutput("post_rst_valid", smp_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
